// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit scheduler: FSM encoding, byte width
// and the default frame spacing in baud ticks.
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam int BYTE_W           = 8;
    // start + 8 data + stop at two ticks per bit, plus one tick of margin
    localparam int UART_FRAME_TICKS = 21;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from ptr.
// Zero latency; grant_valid low when no request is pending.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N_REQ]) begin
                grant_idx   = IDX_W'((int'(ptr) + k) % N_REQ);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart_tx among N_REQ requesters; tx_start 1 clk after a grant, ack 1 clk
// after the sync-tick acceptance, next grant only after FRAME_TICKS ticks of spacing.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int FRAME_TICKS = UART_FRAME_TICKS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sync,
    input  logic [N_REQ-1:0]          req,
    input  logic [BYTE_W*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]          ack,
    output logic                      tx_start,
    output logic [BYTE_W-1:0]         tx_data,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  grant_id
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(FRAME_TICKS) + 1;

    logic [1:0]       state;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req         (req),
        .ptr         (ptr),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            cnt      <= '0;
            ack      <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            grant_id <= '0;
        end else begin
            ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        tx_data  <= req_data[BYTE_W*int'(grant_idx) +: BYTE_W];
                        grant_id <= grant_idx;
                        tx_start <= 1'b1;
                        state    <= ST_ISSUE;
                        if (int'(grant_idx) == N_REQ - 1)
                            ptr <= '0;
                        else
                            ptr <= grant_idx + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    // The transmitter only samples tx_start on a tick.
                    if (sync) begin
                        tx_start      <= 1'b0;
                        ack[grant_id] <= 1'b1;
                        cnt           <= CNT_W'(FRAME_TICKS - 1);
                        state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (sync) begin
                        if (cnt == CNT_W'(1))
                            state <= ST_IDLE;
                        else
                            cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomised and directed bench for uart_tx_sched against a transaction-level
// reference model (byte in flight + remaining spacing ticks + round-robin pointer).
module tb_uart_tx_sched;

    localparam int N  = 4;
    localparam int FT = 21;

    logic           clk = 1'b0;
    logic           rst;
    logic           sync;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   ack;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           busy;
    logic [1:0]     grant_id;

    uart_tx_sched #(.N_REQ(N), .FRAME_TICKS(FT)) dut (
        .clk      (clk),
        .rst      (rst),
        .sync     (sync),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .busy     (busy),
        .grant_id (grant_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model
    bit         m_inflight;
    int         m_gap;
    int         m_ptr;
    int         m_gid;
    logic [7:0] m_byte;
    logic [N-1:0] m_ack;

    int ack_log[$];
    int acc_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_inflight = 1'b0;
        m_gap      = 0;
        m_ptr      = 0;
        m_gid      = 0;
        m_byte     = 8'h00;
        m_ack      = '0;
    endtask

    // One clock of the abstract model, using the inputs applied before the edge.
    task automatic model_edge();
        bit found;
        found = 1'b0;
        m_ack = '0;
        if (m_inflight) begin
            if (sync) begin
                m_inflight   = 1'b0;
                m_ack[m_gid] = 1'b1;
                m_gap        = FT - 1;
            end
        end else if (m_gap > 0) begin
            if (sync) m_gap--;
        end else if (req != '0) begin
            for (int k = 0; k < N; k++) begin
                if (!found && req[(m_ptr + k) % N]) begin
                    found = 1'b1;
                    m_gid = (m_ptr + k) % N;
                end
            end
            m_byte     = req_data[m_gid*8 +: 8];
            m_inflight = 1'b1;
            m_ptr      = (m_gid + 1) % N;
        end
    endtask

    function automatic bit m_busy();
        return m_inflight || (m_gap > 0);
    endfunction

    task automatic step();
        if (tx_start && sync) acc_q.push_back(cyc);
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check("tx_start", tx_start, m_inflight);
        check("tx_data", tx_data, m_byte);
        check("ack", ack, m_ack);
        check("busy", busy, m_busy());
        check("grant_id", grant_id, m_gid);
        for (int i = 0; i < N; i++)
            if (ack[i]) ack_log.push_back(i);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_start"}, tx_start, 1'b0);
        check({tag, "_tx_data"}, tx_data, 8'h00);
        check({tag, "_ack"}, ack, '0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_grant_id"}, grant_id, 2'd0);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        sync = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        ack_log.delete();
        acc_q.delete();
    endtask

    task automatic set_sync(input int period);
        sync = ((cyc % period) == period - 1);
    endtask

    // Run until n acks are logged; requesters drop req on their ack unless held.
    task automatic run_acks(input int n, input int period, input logic [N-1:0] held, input int budget);
        int c;
        c = 0;
        while (ack_log.size() < n && c < budget) begin
            set_sync(period);
            step();
            for (int i = 0; i < N; i++)
                if (ack[i] && !held[i]) req[i] = 1'b0;
            c++;
        end
        check("ack_count", ack_log.size(), n);
    endtask

    task automatic drain(input int period, input int budget);
        int c;
        c = 0;
        while (m_busy() && c < budget) begin
            set_sync(period);
            step();
            c++;
        end
        check("drain_idle", busy, 1'b0);
    endtask

    task automatic check_seq(input string tag, input int e[$]);
        check({tag, "_len"}, ack_log.size(), e.size());
        for (int i = 0; i < e.size() && i < ack_log.size(); i++)
            check({tag, "_idx"}, ack_log[i], e[i]);
    endtask

    int exp_seq[$];

    initial begin
        rst      = 1'b1;
        sync     = 1'b0;
        req      = '0;
        req_data = '0;
        model_reset();
        #1;
        check_reset_outputs("por");
        do_reset();

        // single request, byte 0xA5, tick every 4 clk
        req_data[7:0] = 8'hA5;
        req = 4'b0001;
        run_acks(1, 4, 4'b0000, 400);
        drain(4, 400);
        exp_seq = '{0};
        check_seq("single", exp_seq);

        // all four at once: order 0,1,2,3 and at least FT ticks apart
        do_reset();
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req = 4'b1111;
        run_acks(4, 4, 4'b0000, 2000);
        drain(4, 400);
        exp_seq = '{0, 1, 2, 3};
        check_seq("all4", exp_seq);
        for (int i = 1; i < acc_q.size(); i++)
            check("all4_spacing", (acc_q[i] - acc_q[i-1]) >= FT*4, 1'b1);

        // 0 and 2 held continuously: 0,2,0,2
        do_reset();
        req_data = {8'h33, 8'h22, 8'h11, 8'h00};
        req = 4'b0101;
        run_acks(4, 4, 4'b0101, 2000);
        exp_seq = '{0, 2, 0, 2};
        check_seq("pair", exp_seq);
        req = '0;
        drain(4, 400);

        // requester 1 abandons after tx_start rises; byte still goes out
        do_reset();
        req_data = '0;
        req_data[15:8] = 8'h5A;
        req = 4'b0010;
        sync = 1'b0;
        step();
        check("abandon_start", tx_start, 1'b1);
        step();
        req = '0;
        run_acks(1, 4, 4'b0000, 400);
        drain(4, 400);
        for (int i = 0; i < 12; i++) begin
            set_sync(3);
            step();
        end
        exp_seq = '{1};
        check_seq("abandon", exp_seq);

        // async reset in the middle of WAIT, then requester 3 wins at once
        do_reset();
        req_data = {8'h3C, 8'h00, 8'h00, 8'h77};
        req = 4'b0001;
        run_acks(1, 2, 4'b0000, 200);
        for (int i = 0; i < 6; i++) begin
            set_sync(2);
            step();
        end
        check("wait_busy", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midwait");
        model_reset();
        @(posedge clk);
        #1;
        check("midwait_noack", ack, '0);
        @(negedge clk);
        rst = 1'b0;
        ack_log.delete();
        req = 4'b1000;
        sync = 1'b0;
        step();
        check("post_rst_grant", grant_id, 2'd3);
        check("post_rst_data", tx_data, 8'h3C);
        run_acks(1, 2, 4'b0000, 200);
        drain(2, 200);

        // sync tied high, requester 0 held: acceptances every FT+1 cycles
        do_reset();
        req_data[7:0] = 8'hC3;
        req = 4'b0001;
        for (int i = 0; i < 120; i++) begin
            sync = 1'b1;
            step();
        end
        check("fast_acc_count", acc_q.size() >= 5, 1'b1);
        for (int i = 1; i < acc_q.size(); i++)
            check("fast_spacing", acc_q[i] - acc_q[i-1], FT + 1);
        req = '0;
        drain(1, 100);

        // randomised traffic with occasional abandonment
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            sync = ($urandom_range(0, 2) == 0);
            step();
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(0, 7) == 0) begin
                        req_data[i*8 +: 8] = 8'($urandom);
                        req[i] = 1'b1;
                    end
                end else if (m_busy() && $urandom_range(0, 63) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
        check("rand_activity", ack_log.size() > 20, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
